mux_four_to_one: RTL and testbench



---
 rtl/mux_four_to_one_pkg.sv | 12 +
 rtl/mux_four_to_one_if.sv | 31 +++
 rtl/mux_four_to_one_mux4_comb.sv | 23 ++
 rtl/mux_four_to_one.sv | 54 +++++
 tb/tb_mux_four_to_one.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/mux_four_to_one_pkg.sv
// Shared constants for the registered 4:1 lane selector.
// Select codes map one-to-one onto lane indices.
package mux_four_to_one_pkg;

  localparam int NUM_LANES = 4;

  localparam logic [1:0] SEL_LANE0 = 2'd0;
  localparam logic [1:0] SEL_LANE1 = 2'd1;
  localparam logic [1:0] SEL_LANE2 = 2'd2;
  localparam logic [1:0] SEL_LANE3 = 2'd3;

endpackage

// File: rtl/mux_four_to_one_if.sv
// Signal bundle for the lane selector: capture side (en, i, s) and result side (y, y_valid).
// No valid/ready handshake: en qualifies a capture on the rising edge, y_valid is sticky until reset.
interface mux_four_to_one_if
  import mux_four_to_one_pkg::*;
#(
  parameter int DATA_W = 1
);

  logic                        en;
  logic [NUM_LANES*DATA_W-1:0] i;
  logic [1:0]                  s;
  logic [DATA_W-1:0]           y;
  logic                        y_valid;

  modport master (
    output en,
    output i,
    output s,
    input  y,
    input  y_valid
  );

  modport slave (
    input  en,
    input  i,
    input  s,
    output y,
    output y_valid
  );

endinterface

// File: rtl/mux_four_to_one_mux4_comb.sv
// Purely combinational 4:1 lane picker; lane k occupies i[k*DATA_W +: DATA_W].
module mux4_comb
  import mux_four_to_one_pkg::*;
#(
  parameter int DATA_W = 1
) (
  input  logic [NUM_LANES*DATA_W-1:0] i,
  input  logic [1:0]                  s,
  output logic [DATA_W-1:0]           sel
);

  always_comb begin
    sel = '0;
    case (s)
      SEL_LANE0: sel = i[0*DATA_W +: DATA_W];
      SEL_LANE1: sel = i[1*DATA_W +: DATA_W];
      SEL_LANE2: sel = i[2*DATA_W +: DATA_W];
      SEL_LANE3: sel = i[3*DATA_W +: DATA_W];
      default:   sel = '0;
    endcase
  end

endmodule

// File: rtl/mux_four_to_one.sv
// Registered 4:1 selector: the chosen lane appears on y one clock after an enabled edge.
// y_valid rises on the first enabled capture after reset and stays high until the next reset.
module mux_four_to_one
  import mux_four_to_one_pkg::*;
#(
  parameter int DATA_W = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic [NUM_LANES*DATA_W-1:0] i,
  input  logic [1:0]                  s,
  output logic [DATA_W-1:0]           y,
  output logic                        y_valid
);

  logic [DATA_W-1:0] sel;
  logic [DATA_W-1:0] y_d;
  logic [DATA_W-1:0] y_q;
  logic              y_valid_d;
  logic              y_valid_q;

  mux4_comb #(
    .DATA_W (DATA_W)
  ) u_mux4_comb (
    .i   (i),
    .s   (s),
    .sel (sel)
  );

  always_comb begin
    y_d       = y_q;
    y_valid_d = y_valid_q;
    if (en) begin
      y_d       = sel;
      y_valid_d = 1'b1;
    end
  end

  // Reset takes priority over en, so a mid-stream reset always clears both outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_q       <= '0;
      y_valid_q <= 1'b0;
    end else begin
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
    end
  end

  assign y       = y_q;
  assign y_valid = y_valid_q;

endmodule

// File: tb/tb_mux_four_to_one.sv
// Directed bench for mux_four_to_one: 1-bit lanes (main instance) and 8-bit lanes (second instance).
module tb_mux_four_to_one;

  logic clk;
  logic rst_n;

  int checks;
  int failures;

  mux_four_to_one_if #(.DATA_W(1)) n_if ();
  mux_four_to_one_if #(.DATA_W(8)) w_if ();

  mux_four_to_one #(
    .DATA_W (1)
  ) u_dut_n (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (n_if.en),
    .i       (n_if.i),
    .s       (n_if.s),
    .y       (n_if.y),
    .y_valid (n_if.y_valid)
  );

  mux_four_to_one #(
    .DATA_W (8)
  ) u_dut_w (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (w_if.en),
    .i       (w_if.i),
    .s       (w_if.s),
    .y       (w_if.y),
    .y_valid (w_if.y_valid)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // one rising edge, then settle so outputs are sampled away from the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [31:0] observed,
                           input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // driver: apply a narrow vector, clock it in, check y one edge later
  task automatic apply_n(input string tag, input logic [3:0] iv, input logic [1:0] sv,
                         input logic expected);
    n_if.en = 1'b1;
    n_if.i  = iv;
    n_if.s  = sv;
    step();
    check_val(tag, {31'd0, n_if.y}, {31'd0, expected});
  endtask

  logic [3:0]  exp_i;
  logic        exp_y;
  logic [7:0]  wide_exp [4];

  initial begin
    checks   = 0;
    failures = 0;

    // reset with en high and all-ones input
    rst_n     = 1'b0;
    n_if.en   = 1'b1;
    n_if.i    = 4'b1111;
    n_if.s    = 2'd3;
    w_if.en   = 1'b1;
    w_if.i    = '1;
    w_if.s    = 2'd0;
    step();
    check_val("rst_y_e1", {31'd0, n_if.y}, 32'd0);
    check_val("rst_v_e1", {31'd0, n_if.y_valid}, 32'd0);
    step();
    check_val("rst_y_e2", {31'd0, n_if.y}, 32'd0);
    check_val("rst_v_e2", {31'd0, n_if.y_valid}, 32'd0);
    check_val("rst_wy", {24'd0, w_if.y}, 32'd0);
    check_val("rst_wv", {31'd0, w_if.y_valid}, 32'd0);

    rst_n = 1'b1;
    step();
    check_val("first_cap_y", {31'd0, n_if.y}, 32'd1);
    check_val("first_cap_v", {31'd0, n_if.y_valid}, 32'd1);

    // lane sweep
    apply_n("sweep_0001_s0", 4'b0001, 2'd0, 1'b1);
    apply_n("sweep_0010_s0", 4'b0010, 2'd0, 1'b0);
    apply_n("sweep_0010_s1", 4'b0010, 2'd1, 1'b1);
    apply_n("sweep_1000_s2", 4'b1000, 2'd2, 1'b0);
    apply_n("sweep_1000_s3", 4'b1000, 2'd3, 1'b1);

    // mixed patterns
    apply_n("mix_1111_s0", 4'b1111, 2'd0, 1'b1);
    apply_n("mix_1010_s1", 4'b1010, 2'd1, 1'b1);
    apply_n("mix_1100_s2", 4'b1100, 2'd2, 1'b1);
    apply_n("mix_0110_s3", 4'b0110, 2'd3, 1'b0);

    // exhaustive: model picks bit s of i
    for (int iv = 0; iv < 16; iv++) begin
      for (int sv = 0; sv < 4; sv++) begin
        exp_i = 4'(iv);
        exp_y = exp_i[sv];
        apply_n($sformatf("exh_i%0d_s%0d", iv, sv), 4'(iv), 2'(sv), exp_y);
      end
    end

    // enable hold
    apply_n("hold_cap", 4'b0001, 2'd0, 1'b1);
    n_if.en = 1'b0;
    n_if.i  = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      step();
      check_val($sformatf("hold_y_%0d", k), {31'd0, n_if.y}, 32'd1);
      check_val($sformatf("hold_v_%0d", k), {31'd0, n_if.y_valid}, 32'd1);
    end
    n_if.en = 1'b1;
    step();
    check_val("hold_release_y", {31'd0, n_if.y}, 32'd0);

    // en toggling every cycle: enabled edges capture, disabled edges hold
    n_if.i = 4'b0100;
    n_if.s = 2'd2;
    n_if.en = 1'b1;
    step();
    check_val("tog_cap1", {31'd0, n_if.y}, 32'd1);
    n_if.en = 1'b0;
    n_if.i  = 4'b0000;
    step();
    check_val("tog_hold", {31'd0, n_if.y}, 32'd1);
    n_if.en = 1'b1;
    step();
    check_val("tog_cap2", {31'd0, n_if.y}, 32'd0);

    // mid-stream reset with en high
    apply_n("mid_cap", 4'b0001, 2'd0, 1'b1);
    rst_n = 1'b0;
    step();
    check_val("mid_rst_y", {31'd0, n_if.y}, 32'd0);
    check_val("mid_rst_v", {31'd0, n_if.y_valid}, 32'd0);
    rst_n = 1'b1;
    step();
    check_val("mid_resume_y", {31'd0, n_if.y}, 32'd1);
    check_val("mid_resume_v", {31'd0, n_if.y_valid}, 32'd1);

    // y_valid must stay low after reset until the first enabled edge
    rst_n = 1'b0;
    step();
    rst_n   = 1'b1;
    n_if.en = 1'b0;
    w_if.en = 1'b0;
    step();
    check_val("post_rst_noen_v", {31'd0, n_if.y_valid}, 32'd0);
    check_val("post_rst_noen_y", {31'd0, n_if.y}, 32'd0);
    check_val("post_rst_noen_wv", {31'd0, w_if.y_valid}, 32'd0);
    n_if.en = 1'b1;
    step();
    check_val("post_rst_en_v", {31'd0, n_if.y_valid}, 32'd1);

    // wide lanes
    wide_exp[0] = 8'hAA;
    wide_exp[1] = 8'hBB;
    wide_exp[2] = 8'hCC;
    wide_exp[3] = 8'hDD;
    w_if.en = 1'b1;
    w_if.i  = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
    for (int k = 0; k < 4; k++) begin
      w_if.s = 2'(k);
      step();
      check_val($sformatf("wide_s%0d", k), {24'd0, w_if.y}, {24'd0, wide_exp[k]});
    end
    check_val("wide_v", {31'd0, w_if.y_valid}, 32'd1);
    w_if.en = 1'b0;
    w_if.s  = 2'd1;
    step();
    check_val("wide_hold", {24'd0, w_if.y}, 32'h0000_00DD);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
